// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding and BCD digit constants.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit add: a + b + carry with the +6 correction whenever the raw sum exceeds 9.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c,
  output logic [DIGIT_W-1:0] s,
  output logic               c_next
);
  logic [DIGIT_W:0] t;

  // Non-BCD digits go through the same rule, so results stay deterministic for any input.
  always_comb begin
    t      = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, c};
    s      = t[DIGIT_W-1:0];
    c_next = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      s      = t[DIGIT_W-1:0] + BCD_CORR;
      c_next = 1'b1;
    end
  end
endmodule

// File: rtl/bcd_serial_acc.sv
// Digit-serial BCD adder, LSD first, one digit per clock through a single shared digit step.
// Optional invalid-digit flag built only when BCD_INVALID_CHECK_EN is defined.
module bcd_serial_acc
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                    c_in,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                    c_out,
  output logic                    err
);
  localparam int CW = $clog2(DIGITS) + 1;

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DIGITS-1:0][DIGIT_W-1:0] a_q, b_q, sum_q;
  logic carry, c_out_q, done_q;
  logic [DIGIT_W-1:0] a_k, b_k, s_k;
  logic c_k, last;

  assign last  = (cnt == CW'(DIGITS - 1));
  assign busy  = (state == S_RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Digit mux: select operand digit cnt for the shared step.
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cnt == CW'(k)) begin
        a_k = a_q[k];
        b_k = b_q[k];
      end
    end
  end

  bcd_digit_step u_step (
    .a      (a_k),
    .b      (b_k),
    .c      (carry),
    .s      (s_k),
    .c_next (c_k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      c_out_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Registered pulse: done rises one edge after DONE so sum/c_out are already stable.
      done_q <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= c_in;
            cnt   <= '0;
            sum_q <= '0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (cnt == CW'(k)) sum_q[k] <= s_k;
          end
          carry <= c_k;
          cnt   <= cnt + 1'b1;
          if (last) c_out_q <= c_k;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic err_q;
  assign err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if (state == S_RUN && (a_k > BCD_MAX || b_k > BCD_MAX)) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule
